// File: rtl/counter_datapath.sv
// counter_datapath: step register s and value register y executing control_path commands,
// with the y_inc carry look-ahead, a sticky y overflow flag and a change strobe.
module counter_datapath #(
    parameter int S_WIDTH  = 3,
    parameter int Y_WIDTH  = 8,
    parameter int CARRY_AT = 3,
    parameter int Y_MAX    = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [Y_WIDTH-1:0] x,
    input  logic               y_en,
    input  logic               y_store_x,
    input  logic [1:0]         y_select_next,
    input  logic               s_en,
    input  logic               s_zero,
    input  logic               s_add,
    input  logic [1:0]         s_step,
    output logic               y_inc,
    output logic [S_WIDTH-1:0] s_out,
    output logic [Y_WIDTH-1:0] y_out,
    output logic               y_ovf,
    output logic               upd
);
    localparam logic [S_WIDTH:0]   CA = (S_WIDTH+1)'(CARRY_AT);
    localparam logic [S_WIDTH-1:0] CL = S_WIDTH'(CARRY_AT - 1);
    localparam logic [Y_WIDTH-1:0] YM = Y_WIDTH'(Y_MAX);
    logic [S_WIDTH-1:0] s, s_next;
    logic [Y_WIDTH-1:0] y, y_next;
    logic               ovf, ovf_next, y_wrap;
    logic [S_WIDTH:0]   b, r;
    always_comb begin
        b = s_zero ? '0 : {1'b0, s};
        r = s_add ? b + (S_WIDTH+1)'(s_step) : b - (S_WIDTH+1)'(s_step);
        // add mode wraps by a single subtraction, so an already-large base is only partly corrected
        s_next = !s_en ? s : (s_add && r >= CA) ? S_WIDTH'(r - CA) : S_WIDTH'(r);
        y_wrap = y_en && !y_store_x && y_select_next == 2'd1 && y == YM;
        y_next = !y_en ? y :
                 y_store_x ? x :
                 y_select_next == 2'd1 ? (y == YM ? '0 : y + Y_WIDTH'(1)) :
                 y_select_next == 2'd2 ? (y == '0 ? '0 : y - Y_WIDTH'(1)) :
                 y_select_next == 2'd3 ? '0 : y;
        ovf_next = y_wrap ? 1'b1 : (y_en && (y_store_x || y_select_next == 2'd3)) ? 1'b0 : ovf;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            s   <= '0;
            y   <= '0;
            ovf <= 1'b0;
            upd <= 1'b0;
        end else begin
            s   <= s_next;
            y   <= y_next;
            ovf <= ovf_next;
            upd <= (s_next != s) || (y_next != y);
        end
    end
    assign y_inc = (s == CL);
    assign s_out = s;
    assign y_out = y;
    assign y_ovf = ovf;
endmodule

// File: tb/tb_counter_datapath.sv
// tb_counter_datapath: scenario tasks drive commands, push model expectations, and compare after each edge.
module tb_counter_datapath;
    logic       clk = 1'b0;
    logic       rst, y_en, y_store_x, s_en, s_zero, s_add;
    logic [1:0] y_select_next, s_step;
    logic [7:0] x;
    logic       y_inc, y_ovf, upd;
    logic [2:0] s_out;
    logic [7:0] y_out;

    typedef struct {
        logic [2:0] s;
        logic [7:0] y;
        logic       ovf;
        logic       upd;
        logic       inc;
        string      name;
    } exp_t;
    exp_t q[$];

    int checks = 0;
    int errors = 0;
    int m_s = 0, m_y = 0, m_ovf = 0;

    always #5 clk = ~clk;

    counter_datapath dut (
        .clk(clk), .rst(rst), .x(x), .y_en(y_en), .y_store_x(y_store_x),
        .y_select_next(y_select_next), .s_en(s_en), .s_zero(s_zero), .s_add(s_add),
        .s_step(s_step), .y_inc(y_inc), .s_out(s_out), .y_out(y_out), .y_ovf(y_ovf), .upd(upd)
    );

    task automatic cmd(input logic r, input logic se, input logic sz, input logic sa,
                       input int st, input logic ye, input logic ys, input int sel,
                       input int xv, input string name);
        int ns, ny, novf, b, t;
        exp_t e;
        rst = r; s_en = se; s_zero = sz; s_add = sa; s_step = 2'(st);
        y_en = ye; y_store_x = ys; y_select_next = 2'(sel); x = 8'(xv);
        ns = m_s; ny = m_y; novf = m_ovf;
        if (se) begin
            b = sz ? 0 : m_s;
            if (sa) begin
                t = b + st;
                if (t >= 3) t = t - 3;
                ns = t & 7;
            end else ns = (b - st) & 7;
        end
        if (ye) begin
            if (ys) begin
                ny = xv & 255; novf = 0;
            end else case (sel)
                1: if (m_y == 255) begin ny = 0; novf = 1; end else ny = m_y + 1;
                2: ny = (m_y == 0) ? 0 : m_y - 1;
                3: begin ny = 0; novf = 0; end
                default: ;
            endcase
        end
        if (r) begin
            ns = 0; ny = 0; novf = 0;
            e.upd = 1'b0;
        end else e.upd = (ns != m_s) || (ny != m_y);
        e.s = 3'(ns); e.y = 8'(ny); e.ovf = novf[0]; e.inc = (ns == 2); e.name = name;
        m_s = ns; m_y = ny; m_ovf = novf;
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        checks += 5;
        if (s_out !== e.s) begin errors++; $display("FAIL %s s_out got %0d want %0d", e.name, s_out, e.s); end
        if (y_out !== e.y) begin errors++; $display("FAIL %s y_out got %0h want %0h", e.name, y_out, e.y); end
        if (y_ovf !== e.ovf) begin errors++; $display("FAIL %s y_ovf got %b want %b", e.name, y_ovf, e.ovf); end
        if (upd !== e.upd) begin errors++; $display("FAIL %s upd got %b want %b", e.name, upd, e.upd); end
        if (y_inc !== e.inc) begin errors++; $display("FAIL %s y_inc got %b want %b", e.name, y_inc, e.inc); end
    endtask

    task automatic idle(input string name);
        cmd(0, 0, 0, 0, 0, 0, 0, 0, 0, name);
    endtask

    task automatic test_reset();
        cmd(1, 1, 0, 1, 3, 1, 1, 0, 8'hff, "reset0");
        cmd(1, 1, 0, 1, 3, 1, 0, 1, 8'hff, "reset1");
        checks++;
        if (s_out !== 3'd0 || y_out !== 8'd0 || y_inc !== 1'b0) begin
            errors++; $display("FAIL reset_const s=%0d y=%0d inc=%b want 0 0 0", s_out, y_out, y_inc);
        end
    endtask

    task automatic test_sub_wrap();
        cmd(0, 1, 1, 0, 2, 0, 0, 0, 0, "sub_zero_wrap");
        checks++;
        if (s_out !== 3'd6 || upd !== 1'b1) begin
            errors++; $display("FAIL sub_wrap_const s=%0d upd=%b want 6 1", s_out, upd);
        end
        cmd(0, 1, 0, 0, 2, 0, 0, 0, 0, "sub_to_4");
        cmd(0, 1, 0, 0, 2, 0, 0, 0, 0, "sub_to_2");
        cmd(0, 1, 0, 0, 2, 0, 0, 0, 0, "sub_to_0");
        cmd(0, 1, 0, 0, 0, 0, 0, 0, 0, "step0_hold");
        cmd(0, 0, 1, 1, 3, 0, 0, 0, 0, "s_en_low");
    endtask

    task automatic test_add_carry();
        cmd(0, 1, 0, 1, 1, 0, 0, 0, 0, "add_to_1");
        cmd(0, 1, 0, 1, 1, 0, 0, 0, 0, "add_to_2");
        cmd(0, 1, 0, 1, 1, 1, 0, 1, 0, "add_carry_y");
        checks++;
        if (s_out !== 3'd0 || y_out !== 8'd1) begin
            errors++; $display("FAIL carry_const s=%0d y=%0d want 0 1", s_out, y_out);
        end
        cmd(0, 1, 1, 0, 2, 0, 0, 0, 0, "to_6");
        cmd(0, 1, 0, 1, 1, 0, 0, 0, 0, "add_big_base");
        checks++;
        if (s_out !== 3'd4) begin errors++; $display("FAIL big_base_const s=%0d want 4", s_out); end
        cmd(0, 1, 1, 1, 0, 0, 0, 0, 0, "zero_step0_clear");
    endtask

    task automatic test_load_sat();
        cmd(0, 0, 0, 0, 0, 1, 1, 2, 8'ha5, "load_a5");
        checks++;
        if (y_out !== 8'ha5) begin errors++; $display("FAIL load_const y=%0h want a5", y_out); end
        cmd(0, 0, 0, 0, 0, 1, 1, 0, 8'h01, "load_1");
        cmd(0, 0, 0, 0, 0, 1, 0, 2, 0, "dec_to_0");
        cmd(0, 0, 0, 0, 0, 1, 0, 2, 0, "dec_sat");
        cmd(0, 0, 0, 0, 0, 1, 1, 0, 0, "load_same");
    endtask

    task automatic test_wrap();
        cmd(0, 0, 0, 0, 0, 1, 1, 0, 8'hff, "load_ff");
        cmd(0, 0, 0, 0, 0, 1, 0, 1, 0, "inc_wrap");
        checks++;
        if (y_out !== 8'd0 || y_ovf !== 1'b1) begin
            errors++; $display("FAIL wrap_const y=%0d ovf=%b want 0 1", y_out, y_ovf);
        end
        cmd(0, 0, 0, 0, 0, 1, 0, 1, 0, "inc_after_wrap");
        cmd(0, 0, 0, 0, 0, 1, 0, 2, 0, "dec_keeps_ovf");
        cmd(0, 0, 0, 0, 0, 0, 0, 3, 0, "y_en_low");
        cmd(0, 0, 0, 0, 0, 1, 0, 0, 0, "y_hold");
        cmd(0, 0, 0, 0, 0, 1, 0, 3, 0, "clear");
    endtask

    task automatic test_back_to_back();
        cmd(0, 1, 0, 1, 2, 1, 1, 0, 8'h3c, "both_cmds");
        cmd(1, 1, 0, 1, 2, 1, 1, 0, 8'h3c, "reset_held");
        for (int i = 0; i < 40; i++)
            cmd(($urandom_range(0, 19) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
                $urandom_range(0, 3), 1'($urandom), ($urandom_range(0, 3) == 0),
                $urandom_range(0, 3), $urandom_range(250, 255), "random");
        idle("idle_end");
    endtask

    initial begin
        test_reset();
        test_sub_wrap();
        test_add_carry();
        test_load_sat();
        test_wrap();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
